// File: rtl/vga_pattern_pkg.sv
// Shared types and constants for the VGA test-pattern generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_pattern_pkg;

    typedef enum logic [2:0] {
        PAT_BARS  = 3'd0,
        PAT_CBAR  = 3'd1,
        PAT_CHECK = 3'd2,
        PAT_RAMP  = 3'd3
    } pat_mode_t;

    localparam int FRAME_CNT_W = 16;

    // {r,g,b} per bar, left to right: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [2:0] CBAR_RGB [8] = '{
        3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
    };

endpackage

// File: rtl/vga_offset_acc.sv
// Modular scroll-offset accumulator: off <= (off + step) mod MOD on each enabled cycle.
// Latency: one cycle from enable to updated offset.
// Backpressure: none; i_hold freezes the offset.
module vga_offset_acc #(
    parameter int MOD    = 640,
    parameter int W      = 11,
    parameter int STEP_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_hold,
    input  logic [STEP_W-1:0] i_step,
    output logic [W-1:0]      o_off
);

    logic [W:0] sum;

    // One conditional subtraction suffices because step < MOD
    assign sum = {1'b0, o_off} + (W+1)'(i_step);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_off <= '0;
        end else if (i_en && !i_hold) begin
            o_off <= (sum >= (W+1)'(MOD)) ? W'(sum - (W+1)'(MOD)) : sum[W-1:0];
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// Maps pixel coordinates to RGB test patterns; mode and scroll offsets update on frame ticks.
// Latency: one cycle, all outputs registered.
// Backpressure: none; a pixel is accepted every cycle.
module vga_pattern_gen
    import vga_pattern_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int COORD_W  = 11,
    parameter int COLOR_W  = 10,
    parameter int STEP_W   = 4,
    parameter int BAR_W    = 200,
    parameter int BAR_H    = 150,
    parameter int DIAG_W   = 300,
    parameter int CHK_LOG2 = 5
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [COORD_W-1:0]     i_x,
    input  logic [COORD_W-1:0]     i_y,
    input  logic                   i_valid,
    input  logic [2:0]             i_mode,
    input  logic [STEP_W-1:0]      i_step,
    input  logic                   i_freeze,
    output logic [COLOR_W-1:0]     o_red,
    output logic [COLOR_W-1:0]     o_green,
    output logic [COLOR_W-1:0]     o_blue,
    output logic                   o_valid,
    output logic [FRAME_CNT_W-1:0] o_frame_cnt
);

    localparam int PW       = COORD_W + 2;
    localparam int D_MOD    = H_ACTIVE + V_ACTIVE;
    localparam int GRAD_K   = (2**COLOR_W * 256) / H_ACTIVE;
    localparam int RAMP_MAX = 2**COLOR_W - 1;

    function automatic logic [7:0][COORD_W-1:0] bar_bounds();
        for (int k = 0; k < 8; k++) begin
            bar_bounds[k] = COORD_W'((k * H_ACTIVE) / 8);
        end
    endfunction

    localparam logic [7:0][COORD_W-1:0] CBAR_BND = bar_bounds();

    // Half-open window [off, off+w), wrapping around modulus m
    function automatic logic in_win(input logic [PW-1:0] p, input logic [PW-1:0] off,
                                    input logic [PW-1:0] w, input logic [PW-1:0] m);
        logic [PW-1:0] e;
        e = off + w;
        if (e <= m) return (p >= off) && (p < e);
        return (p >= off) || (p < e - m);
    endfunction

    logic [COORD_W-1:0] x_off, y_off, d_off;
    pat_mode_t          mode_r;
    logic               frame_tick;
    logic               in_active;

    assign frame_tick = i_valid && (i_x == COORD_W'(H_ACTIVE - 1))
                                && (i_y == COORD_W'(V_ACTIVE - 1));
    assign in_active  = i_valid && (i_x < COORD_W'(H_ACTIVE)) && (i_y < COORD_W'(V_ACTIVE));

    vga_offset_acc #(.MOD(H_ACTIVE), .W(COORD_W), .STEP_W(STEP_W)) u_x_off (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(frame_tick), .i_hold(i_freeze),
        .i_step(i_step), .o_off(x_off)
    );

    vga_offset_acc #(.MOD(V_ACTIVE), .W(COORD_W), .STEP_W(STEP_W)) u_y_off (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(frame_tick), .i_hold(i_freeze),
        .i_step(i_step), .o_off(y_off)
    );

    vga_offset_acc #(.MOD(D_MOD), .W(COORD_W), .STEP_W(STEP_W)) u_d_off (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(frame_tick), .i_hold(i_freeze),
        .i_step(i_step), .o_off(d_off)
    );

    logic               win_x, win_y, win_d;
    logic [2:0]         cbar_idx;
    logic               chk_parity;
    logic [COORD_W:0]   chk_sx, chk_sy;
    logic [31:0]        ramp_prod, ramp_full;
    logic [COLOR_W-1:0] ramp_level;

    always_comb begin
        win_x = in_win(PW'(i_x), PW'(x_off), PW'(BAR_W), PW'(H_ACTIVE));
        win_y = in_win(PW'(i_y), PW'(y_off), PW'(BAR_H), PW'(V_ACTIVE));
        win_d = in_win(PW'(i_x) + PW'(i_y), PW'(d_off), PW'(DIAG_W), PW'(D_MOD));
    end

    always_comb begin
        cbar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (i_x >= CBAR_BND[k]) cbar_idx = cbar_idx + 3'd1;
        end
    end

    always_comb begin
        chk_sx     = {1'b0, i_x} + {1'b0, x_off};
        chk_sy     = {1'b0, i_y} + {1'b0, y_off};
        chk_parity = |(((chk_sx ^ chk_sy) >> CHK_LOG2) & (COORD_W+1)'(1));
    end

    always_comb begin
        ramp_prod  = 32'(i_x) * 32'(GRAD_K);
        ramp_full  = ramp_prod >> 8;
        ramp_level = (ramp_full > 32'(RAMP_MAX)) ? {COLOR_W{1'b1}} : ramp_full[COLOR_W-1:0];
    end

    logic [COLOR_W-1:0] red_d, green_d, blue_d;

    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (in_active) begin
            case (mode_r)
                PAT_BARS: begin
                    red_d   = {COLOR_W{win_y}};
                    green_d = {COLOR_W{win_d}};
                    blue_d  = {COLOR_W{win_x}};
                end
                PAT_CBAR: begin
                    red_d   = {COLOR_W{CBAR_RGB[cbar_idx][2]}};
                    green_d = {COLOR_W{CBAR_RGB[cbar_idx][1]}};
                    blue_d  = {COLOR_W{CBAR_RGB[cbar_idx][0]}};
                end
                PAT_CHECK: begin
                    red_d   = {COLOR_W{chk_parity}};
                    green_d = {COLOR_W{chk_parity}};
                    blue_d  = {COLOR_W{chk_parity}};
                end
                PAT_RAMP: begin
                    red_d   = ramp_level;
                    green_d = ramp_level;
                    blue_d  = ramp_level;
                end
                default: begin
                    red_d   = '0;
                    green_d = '0;
                    blue_d  = '0;
                end
            endcase
        end
    end

    // The tick pixel renders with mode_r as it was before this edge
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mode_r      <= PAT_BARS;
            o_frame_cnt <= '0;
            o_valid     <= 1'b0;
            o_red       <= '0;
            o_green     <= '0;
            o_blue      <= '0;
        end else begin
            if (frame_tick) begin
                mode_r      <= pat_mode_t'(i_mode);
                o_frame_cnt <= o_frame_cnt + 1'b1;
            end
            o_valid <= i_valid;
            o_red   <= red_d;
            o_green <= green_d;
            o_blue  <= blue_d;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed self-checking bench for vga_pattern_gen with hand-computed expectations.
module tb_vga_pattern_gen;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [10:0] i_x, i_y;
    logic        i_valid;
    logic [2:0]  i_mode;
    logic [3:0]  i_step;
    logic        i_freeze;
    logic [9:0]  o_red, o_green, o_blue;
    logic        o_valid;
    logic [15:0] o_frame_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt = 16'd0;

    localparam logic [9:0] ON  = 10'h3FF;
    localparam logic [9:0] OFF = 10'h000;

    vga_pattern_gen dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_x(i_x), .i_y(i_y), .i_valid(i_valid),
        .i_mode(i_mode), .i_step(i_step), .i_freeze(i_freeze),
        .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
        .o_valid(o_valid), .o_frame_cnt(o_frame_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_rgb(input string tag, input logic [9:0] r, input logic [9:0] g,
                             input logic [9:0] b);
        check(tag, {2'b00, o_red, o_green, o_blue}, {2'b00, r, g, b});
    endtask

    // Present one pixel, then sample the registered result just after the edge
    task automatic pix(input int x, input int y, input logic v);
        @(negedge i_clk);
        i_x     = 11'(x);
        i_y     = 11'(y);
        i_valid = v;
        @(posedge i_clk);
        #1;
    endtask

    task automatic tick();
        pix(639, 479, 1'b1);
        exp_cnt = exp_cnt + 16'd1;
    endtask

    initial begin
        i_rst    = 1'b1;
        i_x      = '0;
        i_y      = '0;
        i_valid  = 1'b1;
        i_mode   = 3'd0;
        i_step   = 4'd5;
        i_freeze = 1'b0;

        // Reset held: outputs stay zero even with a valid pixel presented
        repeat (2) @(posedge i_clk);
        #1;
        check_rgb("rst_hold_rgb", OFF, OFF, OFF);
        check("rst_hold_valid", 32'(o_valid), 32'd0);
        check("rst_hold_cnt", 32'(o_frame_cnt), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        // Advance to offsets 50, then reset mid-line
        repeat (10) tick();
        check("cnt_10", 32'(o_frame_cnt), 32'(exp_cnt));
        pix(49, 0, 1'b1);
        check_rgb("off50_x49", OFF, OFF, OFF);
        pix(50, 0, 1'b1);
        check_rgb("off50_x50", OFF, ON, ON);
        #2;
        i_rst = 1'b1;
        #1;
        check_rgb("async_rst_rgb", OFF, OFF, OFF);
        check("async_rst_valid", 32'(o_valid), 32'd0);
        check("async_rst_cnt", 32'(o_frame_cnt), 32'd0);
        @(negedge i_clk);
        i_rst   = 1'b0;
        exp_cnt = 16'd0;
        pix(0, 0, 1'b1);
        check_rgb("post_rst_00", ON, ON, ON);

        // Mode 0 at zero offsets
        pix(200, 150, 1'b1);
        check_rgb("bars_200_150", OFF, OFF, OFF);
        pix(199, 149, 1'b1);
        check_rgb("bars_199_149", ON, OFF, ON);
        check("bars_valid", 32'(o_valid), 32'd1);

        // Offset wrap: 100 ticks -> x=500, y=20, d=500
        repeat (100) tick();
        check("cnt_100", 32'(o_frame_cnt), 32'(exp_cnt));
        pix(30, 400, 1'b1);
        check_rgb("wrap_30_400", OFF, OFF, ON);
        pix(60, 400, 1'b1);
        check_rgb("wrap_60_400", OFF, OFF, OFF);
        // 130 ticks total -> x=10, y=170, d=650
        repeat (30) tick();
        pix(10, 170, 1'b1);
        check_rgb("wrap_10_170", ON, OFF, ON);
        pix(9, 169, 1'b1);
        check_rgb("wrap_9_169", OFF, OFF, OFF);

        // Mode shadowing: request colour bars mid-frame
        i_mode = 3'd1;
        pix(100, 100, 1'b1);
        check_rgb("shadow_pre_tick", OFF, OFF, ON);
        tick();
        pix(0, 0, 1'b1);
        check_rgb("cbar_white", ON, ON, ON);
        pix(79, 0, 1'b1);
        check_rgb("cbar_79", ON, ON, ON);
        pix(80, 0, 1'b1);
        check_rgb("cbar_yellow", ON, ON, OFF);
        pix(559, 0, 1'b1);
        check_rgb("cbar_blue", OFF, OFF, ON);
        pix(639, 0, 1'b1);
        check_rgb("cbar_black", OFF, OFF, OFF);

        // Freeze: offsets stay at x=15, y=175 over three ticks
        i_mode   = 3'd0;
        i_freeze = 1'b1;
        repeat (3) tick();
        check("freeze_cnt", 32'(o_frame_cnt), 32'(exp_cnt));
        pix(15, 175, 1'b1);
        check_rgb("freeze_15_175", ON, OFF, ON);
        pix(14, 174, 1'b1);
        check_rgb("freeze_14_174", OFF, OFF, OFF);

        // Checkerboard with x_off=15, y_off=175
        i_mode = 3'd2;
        tick();
        pix(0, 0, 1'b1);
        check_rgb("chk_0_0", ON, ON, ON);
        pix(17, 0, 1'b1);
        check_rgb("chk_17_0", OFF, OFF, OFF);
        pix(17, 1, 1'b1);
        check_rgb("chk_17_1", OFF, OFF, OFF);
        pix(17, 17, 1'b1);
        check_rgb("chk_17_17", ON, ON, ON);

        // Frame counter wrap
        while (exp_cnt != 16'hFFFF) tick();
        check("cnt_ffff", 32'(o_frame_cnt), 32'h0000FFFF);
        tick();
        check("cnt_wrap", 32'(o_frame_cnt), 32'd0);

        // Grey ramp
        i_mode = 3'd3;
        tick();
        pix(0, 0, 1'b1);
        check_rgb("ramp_0", 10'd0, 10'd0, 10'd0);
        pix(80, 5, 1'b1);
        check_rgb("ramp_80", 10'd127, 10'd127, 10'd127);
        pix(320, 5, 1'b1);
        check_rgb("ramp_320", 10'd511, 10'd511, 10'd511);
        pix(639, 5, 1'b1);
        check_rgb("ramp_639", 10'd1020, 10'd1020, 10'd1020);

        // Blanking
        pix(320, 10, 1'b0);
        check("blank_valid", 32'(o_valid), 32'd0);
        check_rgb("blank_rgb", OFF, OFF, OFF);
        pix(700, 10, 1'b1);
        check("oob_valid", 32'(o_valid), 32'd1);
        check_rgb("oob_rgb", OFF, OFF, OFF);

        // Reserved mode
        i_mode = 3'd5;
        tick();
        check("cnt_final", 32'(o_frame_cnt), 32'(exp_cnt));
        pix(320, 5, 1'b1);
        check_rgb("mode5_black", OFF, OFF, OFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
